// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals around mem_port_arbiter.
// The slave modport is the arbiter's view; master is the requester/memory environment.
interface mem_port_arbiter_if;
  logic        if_req_valid;
  logic [31:0] if_req_addr;
  logic        if_req_ready;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;

  logic        ls_req_valid;
  logic [31:0] ls_req_addr;
  logic        ls_req_we;
  logic [31:0] ls_req_wdata;
  logic [1:0]  ls_req_size;
  logic        ls_req_sext;
  logic        ls_req_ready;
  logic        ls_rsp_valid;
  logic [31:0] ls_rsp_data;

  logic [31:0] mem_addr;
  logic [31:0] mem_offset_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic        mem_sext;
  logic [31:0] mem_data_out;

  modport slave (
    input  if_req_valid, if_req_addr,
    output if_req_ready, if_rsp_valid, if_rsp_data,
    input  ls_req_valid, ls_req_addr, ls_req_we, ls_req_wdata, ls_req_size, ls_req_sext,
    output ls_req_ready, ls_rsp_valid, ls_rsp_data,
    output mem_addr, mem_offset_addr, mem_wdata, mem_we, mem_size, mem_sext,
    input  mem_data_out
  );

  modport master (
    output if_req_valid, if_req_addr,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
    output ls_req_valid, ls_req_addr, ls_req_we, ls_req_wdata, ls_req_size, ls_req_sext,
    input  ls_req_ready, ls_rsp_valid, ls_rsp_data,
    input  mem_addr, mem_offset_addr, mem_wdata, mem_we, mem_size, mem_sext,
    output mem_data_out
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store onto one memory port and routes the registered read data back.
// Optional fetch starvation guard is built when MEM_ARB_STARVE_GUARD_EN is defined.
module mem_port_arbiter #(
  parameter int unsigned STREAK_MAX = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clk_enable,
  mem_port_arbiter_if.slave  bus
);

  localparam logic [3:0] STREAK_LIM = 4'(STREAK_MAX);

  logic        grant_if;
  logic        grant_ls;
  logic        force_if;

  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_we;
  logic [1:0]  sel_size;
  logic        sel_sext;

  logic [31:0] addr_hold;
  logic [31:0] offset_hold;

  logic        vld_if_p1;
  logic        vld_ls_p1;
  logic        store_p1;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [3:0] streak_p1;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    if (v >= STREAK_LIM) return STREAK_LIM;
    return v + 4'd1;
  endfunction

  assign force_if = bus.if_req_valid && (streak_p1 == STREAK_LIM);

  // Counts load/store wins while fetch is waiting; any fetch win or idle fetch resets it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_p1 <= 4'd0;
    end else if (clk_enable) begin
      if (grant_if || !bus.if_req_valid) streak_p1 <= 4'd0;
      else if (grant_ls)                 streak_p1 <= sat_inc(streak_p1);
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^STREAK_LIM;
  assign force_if   = 1'b0;
`endif

  // Stage p0: combinational grant and memory-side drive.
  assign grant_ls = clk_enable && bus.ls_req_valid && !force_if;
  assign grant_if = clk_enable && bus.if_req_valid && (!bus.ls_req_valid || force_if);

  always_comb begin
    sel_addr  = addr_hold;
    sel_wdata = 32'd0;
    sel_we    = 1'b0;
    sel_size  = 2'b00;
    sel_sext  = 1'b0;
    if (grant_ls) begin
      sel_addr  = bus.ls_req_addr;
      sel_wdata = bus.ls_req_wdata;
      sel_we    = bus.ls_req_we;
      sel_size  = bus.ls_req_size;
      sel_sext  = bus.ls_req_sext;
    end else if (grant_if) begin
      sel_addr  = bus.if_req_addr;
      sel_size  = 2'b10;
    end
  end

  assign bus.if_req_ready    = grant_if;
  assign bus.ls_req_ready    = grant_ls;
  assign bus.mem_addr        = sel_addr;
  assign bus.mem_offset_addr = (grant_if || grant_ls) ? sel_addr + 32'd4 : offset_hold;
  assign bus.mem_wdata       = sel_wdata;
  assign bus.mem_we          = sel_we;
  assign bus.mem_size        = sel_size;
  assign bus.mem_sext        = sel_sext;

  // Address outputs keep their last granted value; held offset starts at 0 so reset reads all-zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_hold   <= 32'd0;
      offset_hold <= 32'd0;
    end else if (grant_if || grant_ls) begin
      addr_hold   <= sel_addr;
      offset_hold <= sel_addr + 32'd4;
    end
  end

  // Stage p1: one-cycle read latency tracking, tagged by source.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_if_p1 <= 1'b0;
      vld_ls_p1 <= 1'b0;
      store_p1  <= 1'b0;
    end else if (clk_enable) begin
      vld_if_p1 <= grant_if;
      vld_ls_p1 <= grant_ls;
      store_p1  <= grant_ls && bus.ls_req_we;
    end
  end

  assign bus.if_rsp_valid = vld_if_p1;
  assign bus.if_rsp_data  = vld_if_p1 ? bus.mem_data_out : 32'd0;
  assign bus.ls_rsp_valid = vld_ls_p1;
  assign bus.ls_rsp_data  = (vld_ls_p1 && !store_p1) ? bus.mem_data_out : 32'd0;

endmodule
